// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL_LU = 2'd1,
      STALL_SB = 2'd2
   } hz_state_e;

   localparam int SEL_REGFILE = 0;
   localparam int REG_ZERO    = 0;

   // Select width needed to encode "regfile" plus one code per forwarding stage.
   function automatic int sel_w(input int numFwd);
      return $clog2(numFwd + 1);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency writes: busy bitmap, outstanding count,
// issue-ready flag and sticky overflow error.
module reg_scoreboard
   import hazard_pkg::*;
#(
   parameter int RW     = 5,
   parameter int MAX_LL = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ll_issue,
   input  logic [RW-1:0]    ll_rd,
   input  logic             ll_done,
   input  logic [RW-1:0]    ll_done_rd,
   output logic [2**RW-1:0] sb_busy,
   output logic             ll_ready,
   output logic             ll_ovf_err
);

   localparam int CW = $clog2(MAX_LL + 1);

   logic [2**RW-1:0] busy_q, busy_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             issueOk, doneOk, full;

   // A done only counts against a busy register with something outstanding;
   // an issue is dropped when full or when it targets x0.
   always_comb begin
      full    = (count_q == CW'(MAX_LL));
      doneOk  = ll_done && (count_q != '0) && busy_q[ll_done_rd];
      issueOk = ll_issue && !full && (ll_rd != RW'(REG_ZERO));
      busy_d  = busy_q;
      count_d = count_q;
      ovf_d   = ovf_q | (ll_issue && full);
      if (doneOk) busy_d[ll_done_rd] = 1'b0;
      if (issueOk) busy_d[ll_rd] = 1'b1;
      case ({issueOk, doneOk})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sb_busy    = busy_q;
   assign ll_ready   = (count_q < CW'(MAX_LL));
   assign ll_ovf_err = ovf_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding select, load-use and scoreboard stall unit beside ID.
// Optional stall performance counters are enabled with HAZARD_PERF_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_FWD    = 3,
   parameter int RW         = 5,
   parameter int MAX_LL     = 2,
   parameter int SB_TIMEOUT = 64,
   localparam int SEL_W     = sel_w(NUM_FWD)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [NUM_SRC*RW-1:0]    id_rs,
   input  logic [NUM_SRC-1:0]       id_rs_used,
   input  logic [RW-1:0]            id_rd,
   input  logic                     id_wen,
   input  logic [NUM_FWD-1:0]       fwd_valid,
   input  logic [NUM_FWD-1:0]       fwd_wen,
   input  logic [NUM_FWD*RW-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]       fwd_ready,
   input  logic                     ll_issue,
   input  logic [RW-1:0]            ll_rd,
   input  logic                     ll_done,
   input  logic [RW-1:0]            ll_done_rd,
   input  logic                     flush,
   output logic [NUM_SRC*SEL_W-1:0] src_sel,
   output logic                     stall_id,
   output logic                     bubble_ex,
   output logic                     ll_ready,
   output logic [2**RW-1:0]         sb_busy,
   output logic                     sb_timeout_err,
   output logic                     ll_ovf_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]              perf_lu_cnt,
   output logic [31:0]              perf_sb_cnt
`endif
);

   localparam int WDW = $clog2(SB_TIMEOUT + 1);

   logic [RW-1:0]            srcRs  [NUM_SRC];
   logic [SEL_W-1:0]         srcSel [NUM_SRC];
   logic                     srcRdy [NUM_SRC];
   logic [NUM_SRC*SEL_W-1:0] selRaw;
   logic                     luHit, sbHit, luStall, sbStall;
   hz_state_e                state_q, state_d;
   logic                     wdEn;
   logic [WDW-1:0]           wdCnt_q, wdCnt_d;
   logic                     timeoutErr_q, timeoutErr_d;

   reg_scoreboard #(
      .RW     (RW),
      .MAX_LL (MAX_LL)
   ) uScoreboard (
      .clk        (clk),
      .rst        (rst),
      .ll_issue   (ll_issue),
      .ll_rd      (ll_rd),
      .ll_done    (ll_done),
      .ll_done_rd (ll_done_rd),
      .sb_busy    (sb_busy),
      .ll_ready   (ll_ready),
      .ll_ovf_err (ll_ovf_err)
   );

   // Scan oldest to youngest so the youngest matching stage overrides.
   always_comb begin
      selRaw = '0;
      luHit  = 1'b0;
      sbHit  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         srcRs[i]  = id_rs[i*RW +: RW];
         srcSel[i] = SEL_W'(SEL_REGFILE);
         srcRdy[i] = 1'b1;
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_wen[k] && (fwd_rd[k*RW +: RW] == srcRs[i]) &&
                (srcRs[i] != RW'(REG_ZERO))) begin
               srcSel[i] = SEL_W'(k + 1);
               srcRdy[i] = fwd_ready[k];
            end
         end
         if (id_rs_used[i] && !srcRdy[i]) luHit = 1'b1;
         if (id_rs_used[i] && sb_busy[srcRs[i]]) sbHit = 1'b1;
         selRaw[i*SEL_W +: SEL_W] = srcSel[i];
      end
      if (id_wen && sb_busy[id_rd]) sbHit = 1'b1;
   end

   assign luStall   = id_valid && !flush && !rst && luHit;
   assign sbStall   = id_valid && !flush && !rst && sbHit;
   assign stall_id  = luStall || sbStall;
   assign bubble_ex = stall_id;
   assign src_sel   = rst ? '0 : selRaw;

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = RUN;
      if (flush)        state_d = RUN;
      else if (sbStall) state_d = STALL_SB;
      else if (luStall) state_d = STALL_LU;
   end

   always_comb begin
      wdEn = (state_q == STALL_SB) && sbStall;
   end

   // Watchdog saturates at the timeout so the sticky error cannot be missed.
   always_comb begin
      wdCnt_d = '0;
      if (wdEn) begin
         if (wdCnt_q != WDW'(SB_TIMEOUT)) wdCnt_d = wdCnt_q + WDW'(1);
         else                             wdCnt_d = wdCnt_q;
      end
      timeoutErr_d = timeoutErr_q || (wdCnt_d == WDW'(SB_TIMEOUT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdCnt_q      <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         wdCnt_q      <= wdCnt_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign sb_timeout_err = timeoutErr_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] perfLu_q, perfSb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perfLu_q <= '0;
         perfSb_q <= '0;
      end else begin
         if (luStall && (perfLu_q != '1)) perfLu_q <= perfLu_q + 32'd1;
         if (sbStall && (perfSb_q != '1)) perfSb_q <= perfSb_q + 32'd1;
      end
   end

   assign perf_lu_cnt = perfLu_q;
   assign perf_sb_cnt = perfSb_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_wen;
   logic [2:0]  fwd_valid, fwd_wen, fwd_ready;
   logic [14:0] fwd_rd;
   logic        ll_issue, ll_done, flush;
   logic [4:0]  ll_rd, ll_done_rd;
   logic [3:0]  src_sel;
   logic        stall_id, bubble_ex, ll_ready, sb_timeout_err, ll_ovf_err;
   logic [31:0] sb_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_lu_cnt, perf_sb_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hazard_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_rs          (id_rs),
      .id_rs_used     (id_rs_used),
      .id_rd          (id_rd),
      .id_wen         (id_wen),
      .fwd_valid      (fwd_valid),
      .fwd_wen        (fwd_wen),
      .fwd_rd         (fwd_rd),
      .fwd_ready      (fwd_ready),
      .ll_issue       (ll_issue),
      .ll_rd          (ll_rd),
      .ll_done        (ll_done),
      .ll_done_rd     (ll_done_rd),
      .flush          (flush),
      .src_sel        (src_sel),
      .stall_id       (stall_id),
      .bubble_ex      (bubble_ex),
      .ll_ready       (ll_ready),
      .sb_busy        (sb_busy),
      .sb_timeout_err (sb_timeout_err),
      .ll_ovf_err     (ll_ovf_err)
`ifdef HAZARD_PERF_EN
      ,
      .perf_lu_cnt    (perf_lu_cnt),
      .perf_sb_cnt    (perf_sb_cnt)
`endif
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyIdle();
      id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wen = 0;
      fwd_valid = '0; fwd_wen = '0; fwd_rd = '0; fwd_ready = '1;
      ll_issue = 0; ll_rd = '0; ll_done = 0; ll_done_rd = '0; flush = 0;
   endtask

   task automatic test_reset();
      rst = 1; applyIdle(); step(); step(); rst = 0; #1;
      checks++; if (stall_id !== 1'b0 || bubble_ex !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_stall: got %0b/%0b want 0/0", stall_id, bubble_ex); end
      checks++; if (src_sel !== 4'd0) begin errors++;
         $display("[TB] FAIL reset_sel: got %0h want 0", src_sel); end
      checks++; if (sb_busy !== 32'd0 || ll_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL reset_sb: busy %0h ready %0b want 0/1", sb_busy, ll_ready); end
      checks++; if (sb_timeout_err !== 1'b0 || ll_ovf_err !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_err: got %0b/%0b want 0/0", sb_timeout_err, ll_ovf_err); end
      checks++; if (dut.state_q !== RUN) begin errors++;
         $display("[TB] FAIL reset_state: got %0d want %0d", dut.state_q, RUN); end
   endtask

   task automatic test_forward();
      applyIdle(); step();
      id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b11;
      fwd_valid = 3'b011; fwd_wen = 3'b011; fwd_rd = {5'd0, 5'd5, 5'd5}; #1;
      checks++; if (src_sel !== 4'b0001 || stall_id !== 1'b0) begin errors++;
         $display("[TB] FAIL fwd_youngest: sel %0h stall %0b want 1/0", src_sel, stall_id); end
      id_rs = {5'd6, 5'd8}; fwd_valid = 3'b110; fwd_wen = 3'b110; fwd_rd = {5'd8, 5'd6, 5'd6}; #1;
      checks++; if (src_sel !== 4'b1011) begin errors++;
         $display("[TB] FAIL fwd_mem_wb: sel %0h want b", src_sel); end
      fwd_wen = 3'b100; #1;
      checks++; if (src_sel !== 4'b0011) begin errors++;
         $display("[TB] FAIL fwd_wen_gate: sel %0h want 3", src_sel); end
   endtask

   task automatic test_load_use();
      applyIdle(); step();
      id_valid = 1; id_rs = {5'd7, 5'd1}; id_rs_used = 2'b11;
      fwd_valid = 3'b001; fwd_wen = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd7}; fwd_ready = 3'b110; #1;
      checks++; if (src_sel !== 4'b0100 || stall_id !== 1'b1 || bubble_ex !== 1'b1) begin errors++;
         $display("[TB] FAIL lu_stall: sel %0h stall %0b bub %0b want 4/1/1", src_sel, stall_id, bubble_ex); end
      id_rs_used = 2'b01; #1;
      checks++; if (stall_id !== 1'b0) begin errors++;
         $display("[TB] FAIL lu_unused: stall %0b want 0", stall_id); end
      id_rs_used = 2'b11; flush = 1; #1;
      checks++; if (stall_id !== 1'b0) begin errors++;
         $display("[TB] FAIL lu_flush: stall %0b want 0", stall_id); end
      flush = 0; step();
      checks++; if (dut.state_q !== STALL_LU) begin errors++;
         $display("[TB] FAIL lu_state: got %0d want %0d", dut.state_q, STALL_LU); end
      fwd_valid = 3'b010; fwd_wen = 3'b010; fwd_rd = {5'd0, 5'd7, 5'd0}; fwd_ready = 3'b111; #1;
      checks++; if (src_sel !== 4'b1000 || stall_id !== 1'b0) begin errors++;
         $display("[TB] FAIL lu_resolved: sel %0h stall %0b want 8/0", src_sel, stall_id); end
      step();
      checks++; if (dut.state_q !== RUN) begin errors++;
         $display("[TB] FAIL lu_state_run: got %0d want %0d", dut.state_q, RUN); end
   endtask

   task automatic test_scoreboard();
      applyIdle(); ll_issue = 1; ll_rd = 5'd9; step();
      ll_issue = 0; id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01; #1;
      checks++; if (sb_busy[9] !== 1'b1 || stall_id !== 1'b1) begin errors++;
         $display("[TB] FAIL sb_stall: busy9 %0b stall %0b want 1/1", sb_busy[9], stall_id); end
      step();
      checks++; if (dut.state_q !== STALL_SB) begin errors++;
         $display("[TB] FAIL sb_state: got %0d want %0d", dut.state_q, STALL_SB); end
      ll_done = 1; ll_done_rd = 5'd9; #1;
      checks++; if (stall_id !== 1'b1) begin errors++;
         $display("[TB] FAIL sb_done_cycle: stall %0b want 1", stall_id); end
      step(); ll_done = 0; #1;
      checks++; if (stall_id !== 1'b0 || sb_busy[9] !== 1'b0) begin errors++;
         $display("[TB] FAIL sb_release: stall %0b busy9 %0b want 0/0", stall_id, sb_busy[9]); end
      ll_issue = 1; ll_rd = 5'd10; step();
      ll_issue = 0; id_rs_used = 2'b00; id_wen = 1; id_rd = 5'd10; #1;
      checks++; if (stall_id !== 1'b1) begin errors++;
         $display("[TB] FAIL sb_waw: stall %0b want 1", stall_id); end
      ll_done = 1; ll_done_rd = 5'd10; step(); ll_done = 0; #1;
      checks++; if (stall_id !== 1'b0 || ll_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL sb_waw_clear: stall %0b ready %0b want 0/1", stall_id, ll_ready); end
   endtask

   task automatic test_ll_limit();
      applyIdle();
      ll_issue = 1; ll_rd = 5'd3; step();
      ll_rd = 5'd4; step();
      ll_issue = 0; #1;
      checks++; if (ll_ready !== 1'b0 || ll_ovf_err !== 1'b0) begin errors++;
         $display("[TB] FAIL ll_full: ready %0b ovf %0b want 0/0", ll_ready, ll_ovf_err); end
      ll_issue = 1; ll_rd = 5'd5; step(); ll_issue = 0; #1;
      checks++; if (ll_ovf_err !== 1'b1 || sb_busy[5] !== 1'b0 || ll_ready !== 1'b0) begin errors++;
         $display("[TB] FAIL ll_ovf: ovf %0b busy5 %0b ready %0b want 1/0/0", ll_ovf_err, sb_busy[5], ll_ready); end
      ll_done = 1; ll_done_rd = 5'd3; step();
      ll_done_rd = 5'd4; step();
      step();
      ll_done = 0; #1;
      checks++; if (ll_ready !== 1'b1 || sb_busy !== 32'd0) begin errors++;
         $display("[TB] FAIL ll_underflow: ready %0b busy %0h want 1/0", ll_ready, sb_busy); end
   endtask

   task automatic test_back_to_back();
      applyIdle();
      ll_issue = 1; ll_rd = 5'd3; ll_done = 1; ll_done_rd = 5'd3; step();
      checks++; if (sb_busy[3] !== 1'b1 || ll_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL b2b_idle_rd: busy3 %0b ready %0b want 1/1", sb_busy[3], ll_ready); end
      step(); ll_issue = 0; ll_done = 0; #1;
      checks++; if (sb_busy[3] !== 1'b1 || ll_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL b2b_busy_rd: busy3 %0b ready %0b want 1/1", sb_busy[3], ll_ready); end
      id_valid = 1; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
      fwd_valid = 3'b001; fwd_wen = 3'b001; fwd_rd = '0; fwd_ready = 3'b110; #1;
      checks++; if (src_sel !== 4'd0 || stall_id !== 1'b0) begin errors++;
         $display("[TB] FAIL x0_no_fwd: sel %0h stall %0b want 0/0", src_sel, stall_id); end
      applyIdle(); ll_done = 1; ll_done_rd = 5'd3; step(); ll_done = 0; #1;
      checks++; if (sb_busy !== 32'd0) begin errors++;
         $display("[TB] FAIL b2b_cleanup: busy %0h want 0", sb_busy); end
   endtask

   task automatic test_timeout();
      applyIdle(); ll_issue = 1; ll_rd = 5'd14; step();
      ll_issue = 0; id_valid = 1; id_rs = {5'd0, 5'd14}; id_rs_used = 2'b01;
      fwd_valid = 3'b010; fwd_wen = 3'b010; fwd_rd = {5'd0, 5'd14, 5'd0};
      for (int c = 0; c < 30; c++) step();
      checks++; if (sb_timeout_err !== 1'b0 || stall_id !== 1'b1) begin errors++;
         $display("[TB] FAIL wd_early: err %0b stall %0b want 0/1", sb_timeout_err, stall_id); end
      for (int c = 0; c < 50; c++) step();
      checks++; if (sb_timeout_err !== 1'b1 || src_sel !== 4'b0010) begin errors++;
         $display("[TB] FAIL wd_expired: err %0b sel %0h want 1/2", sb_timeout_err, src_sel); end
      rst = 1; step();
      checks++; if (stall_id !== 1'b0 || sb_busy !== 32'd0 || src_sel !== 4'd0) begin errors++;
         $display("[TB] FAIL rst_mid: stall %0b busy %0h sel %0h want 0/0/0", stall_id, sb_busy, src_sel); end
      checks++; if (sb_timeout_err !== 1'b0 || ll_ovf_err !== 1'b0 || ll_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL rst_mid_err: err %0b ovf %0b ready %0b want 0/0/1", sb_timeout_err, ll_ovf_err, ll_ready); end
      rst = 0; ll_done = 1; ll_done_rd = 5'd14; step(); ll_done = 0; #1;
      checks++; if (ll_ready !== 1'b1 || stall_id !== 1'b0 || dut.state_q !== RUN) begin errors++;
         $display("[TB] FAIL rst_pending_done: ready %0b stall %0b state %0d want 1/0/0", ll_ready, stall_id, dut.state_q); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_scoreboard();
      test_ll_limit();
      test_back_to_back();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
